// File: rtl/quan_conv_out_fifo.sv
// quan_conv_out_fifo
//
// Output collection stage behind the quantized CBR core. Each cycle with in_en
// high, one requantized word is captured together with its output-channel row
// index and a tile-end mark. Words go into a first-word-fall-through circular
// FIFO and are drained over a valid/ready handshake.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_en               write strobe
//   in_data             word to write (DATA_W bits)
//   in_row_idx          output-channel row index of the word
//   in_tile_end         marks the last beat of a tile
//   in_afull            advisory backpressure hint (count >= DEPTH - AFULL_MARGIN)
//   out_valid           FIFO non-empty
//   out_ready           consumer accepts the head word
//   out_data            head word (combinational read, FWFT)
//   out_row_idx         row index of the head word
//   out_last            head word closes its tile
//   count               current occupancy
//   tiles_done          number of popped words carrying the last mark (wraps)
//   tile_done_pulse     registered one-cycle pulse after a last word pops
//   err_overflow        sticky: a write was dropped because the FIFO was full
//   err_len             sticky: a tile's beat count differed from BEATS_PER_TILE
//   err_orphan_end      sticky: in_tile_end seen without in_en

module quan_conv_out_fifo #(
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned DEPTH          = 64,
  parameter int unsigned AFULL_MARGIN   = 20,
  parameter int unsigned BEATS_PER_TILE = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_en,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [5:0]               in_row_idx,
  input  logic                     in_tile_end,
  output logic                     in_afull,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [5:0]               out_row_idx,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              tiles_done,
  output logic                     tile_done_pulse,
  output logic                     err_overflow,
  output logic                     err_len,
  output logic                     err_orphan_end
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BEATS_PER_TILE) + 1;
  localparam int unsigned EW = DATA_W + 7;

  localparam logic [CW-1:0] DepthVal = CW'(DEPTH);
  localparam logic [CW-1:0] AfullVal = CW'(DEPTH - AFULL_MARGIN);
  localparam logic [BW-1:0] BeatsMax = BW'(BEATS_PER_TILE);

  // Entry layout: {last, row_idx[5:0], data}
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [15:0]   tiles_q, tiles_d;
  logic          pulse_q, pulse_d;
  logic          ovf_q, ovf_d;
  logic          len_q, len_d;
  logic          orphan_q, orphan_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] head;
  logic [BW-1:0] beat_inc;

  // Head outputs and handshake
  assign head        = mem_q[rd_ptr_q];
  assign out_data    = head[DATA_W-1:0];
  assign out_row_idx = head[EW-2 -: 6];
  assign out_last    = head[EW-1];
  assign out_valid   = (count_q != '0);
  assign in_afull    = (count_q >= AfullVal);

  assign full = (count_q == DepthVal);
  assign pop  = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = in_en & (~full | pop);
  assign drop = in_en & full & ~pop;

  assign beat_inc = beat_q + BW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    tiles_d  = tiles_q;
    pulse_d  = 1'b0;
    ovf_d    = ovf_q;
    len_d    = len_q;
    orphan_d = orphan_q;

    count_d = count_q + CW'(push) - CW'(pop);

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (in_tile_end) begin
        if (beat_inc != BeatsMax) begin
          len_d = 1'b1;
        end
        beat_d = '0;
      end else if (beat_inc >= BeatsMax) begin
        // Tile ran to full length without its end mark: flag and hold.
        len_d  = 1'b1;
        beat_d = BeatsMax;
      end else begin
        beat_d = beat_inc;
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end

    if (in_tile_end && !in_en) begin
      orphan_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (out_last) begin
        tiles_d = tiles_q + 16'd1;
        pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      tiles_q  <= '0;
      pulse_q  <= 1'b0;
      ovf_q    <= 1'b0;
      len_q    <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      tiles_q  <= tiles_d;
      pulse_q  <= pulse_d;
      ovf_q    <= ovf_d;
      len_q    <= len_d;
      orphan_q <= orphan_d;
    end
  end

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_tile_end, in_row_idx, in_data};
    end
  end

  assign count           = count_q;
  assign tiles_done      = tiles_q;
  assign tile_done_pulse = pulse_q;
  assign err_overflow    = ovf_q;
  assign err_len         = len_q;
  assign err_orphan_end  = orphan_q;

endmodule

// File: tb/tb_quan_conv_out_fifo.sv
// Directed self-checking bench for quan_conv_out_fifo (default parameters).
// A scoreboard queue holds the entries that should be in the FIFO.

module tb_quan_conv_out_fifo;

  localparam int DEPTH = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_en;
  logic [127:0] in_data;
  logic [5:0]   in_row_idx;
  logic         in_tile_end;
  logic         in_afull;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [5:0]   out_row_idx;
  logic         out_last;
  logic [6:0]   count;
  logic [15:0]  tiles_done;
  logic         tile_done_pulse;
  logic         err_overflow;
  logic         err_len;
  logic         err_orphan_end;

  quan_conv_out_fifo dut (
    .clk             (clk),
    .reset           (reset),
    .in_en           (in_en),
    .in_data         (in_data),
    .in_row_idx      (in_row_idx),
    .in_tile_end     (in_tile_end),
    .in_afull        (in_afull),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_row_idx     (out_row_idx),
    .out_last        (out_last),
    .count           (count),
    .tiles_done      (tiles_done),
    .tile_done_pulse (tile_done_pulse),
    .err_overflow    (err_overflow),
    .err_len         (err_len),
    .err_orphan_end  (err_orphan_end)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [134:0] sb[$];
  logic [15:0]  exp_tiles;
  int           pulses;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int i);
    mk = {4{32'hA5C3_0000 + 32'(i)}};
  endfunction

  // One clock cycle: drive inputs, check head against the scoreboard, advance.
  task automatic cyc(input logic en, input logic [127:0] d, input logic [5:0] row,
                     input logic te, input logic rdy);
    logic pop_m, push_m, pulse_m;
    in_en       = en;
    in_data     = d;
    in_row_idx  = row;
    in_tile_end = te;
    out_ready   = rdy;
    pop_m   = rdy && (sb.size() != 0);
    push_m  = en && ((sb.size() < DEPTH) || pop_m);
    pulse_m = 1'b0;
    check_eq("valid", out_valid, sb.size() != 0);
    if (pop_m) begin
      check_eq("head", {out_last, out_row_idx, out_data}, sb[0]);
      pulse_m = sb[0][134];
    end
    @(posedge clk);
    #1;
    if (pop_m) void'(sb.pop_front());
    if (push_m) sb.push_back({te, row, d});
    if (pulse_m) exp_tiles++;
    if (tile_done_pulse) pulses++;
    check_eq("pulse", tile_done_pulse, pulse_m);
    check_eq("count", count, sb.size());
  endtask

  task automatic do_reset(input logic rdy);
    reset       = 1'b1;
    in_en       = 1'b0;
    in_tile_end = 1'b0;
    out_ready   = rdy;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_tiles = '0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_count"}, count, 0);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_afull"}, in_afull, 0);
    check_eq({tag, "_tiles"}, tiles_done, 0);
    check_eq({tag, "_pulse"}, tile_done_pulse, 0);
    check_eq({tag, "_ovf"}, err_overflow, 0);
    check_eq({tag, "_len"}, err_len, 0);
    check_eq({tag, "_orphan"}, err_orphan_end, 0);
  endtask

  initial begin
    int first_afull;
    reset = 1'b1; in_en = 1'b0; in_data = '0; in_row_idx = '0;
    in_tile_end = 1'b0; out_ready = 1'b0;
    exp_tiles = '0; pulses = 0;
    @(posedge clk);
    #1;
    do_reset(1'b0);
    check_idle("rst");

    // Single tile, consumer always ready
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, mk(i), 6'(i), i == 15, 1'b1);
      if (i == 0) check_eq("empty_push_count", count, 1);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("t1_tiles", tiles_done, 1);
    check_eq("t1_pulses", pulses, 1);
    check_eq("t1_len", err_len, 0);
    check_eq("t1_ovf", err_overflow, 0);
    check_eq("t1_orphan", err_orphan_end, 0);

    // Fill and overflow
    do_reset(1'b0);
    first_afull = -1;
    for (int i = 0; i < 65; i++) begin
      if (i == 64) check_eq("ovf_before", err_overflow, 0);
      cyc(1'b1, mk(100 + i), 6'(i), 1'b0, 1'b0);
      if (in_afull && first_afull < 0) first_afull = int'(count);
    end
    check_eq("fill_count", count, 64);
    check_eq("afull_rise", first_afull, 44);
    check_eq("ovf_set", err_overflow, 1);
    for (int i = 0; i < 64; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("drain_empty", out_valid, 0);
    check_eq("drain_afull", in_afull, 0);

    // Full with simultaneous push and pop
    do_reset(1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b1, mk(200 + i), 6'(i), 1'b0, 1'b0);
    cyc(1'b1, mk(999), 6'd63, 1'b0, 1'b1);
    check_eq("fullpp_count", count, 64);
    check_eq("fullpp_ovf", err_overflow, 0);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check_eq("fullpp_newlast", out_data, mk(999));
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
    end

    // Short tile then a correct one
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, mk(300 + i), 6'(i), i == 11, 1'b1);
    check_eq("short_len", err_len, 1);
    for (int i = 0; i < 16; i++) cyc(1'b1, mk(400 + i), 6'(i), i == 15, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("short_tiles", tiles_done, exp_tiles);
    check_eq("short_tiles2", tiles_done, 2);
    check_eq("short_ovf", err_overflow, 0);

    // Orphan tile end
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(500 + i), 6'(i), 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("orphan_flag", err_orphan_end, 1);
    check_eq("orphan_count", count, 3);

    // Reset during drain
    for (int i = 0; i < 7; i++) cyc(1'b1, mk(600 + i), 6'(i), 1'b0, 1'b0);
    check_eq("pre_rst_count", count, 10);
    check_eq("pre_rst_tiles", tiles_done, 2);
    do_reset(1'b1);
    check_idle("mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
